rx_frame_decoder: RTL and testbench

// - Downstream of the per-module UART receiver: takes each completed 9-bit frame (8 data + parity),

---
 rtl/rx_frame_decoder.sv | 160 ++++++++++++++++
 tb/tb_rx_frame_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_decoder.sv
// Frame decoder behind the UART receiver: SECDED-decodes Hamming(8,4) bytes into a command FIFO.
// Optional saturating error counters are enabled with `define RX_ERR_CNT_EN.
module rx_frame_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    input  logic                 rx_parity_err,
    output logic [3:0]           m_data,
    output logic                 m_corrected,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 drop_parity,
    output logic                 drop_ecc,
    output logic                 drop_ovf
`ifdef RX_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] err_cnt_par,
    output logic [CNT_WIDTH-1:0] err_cnt_ecc,
    output logic [CNT_WIDTH-1:0] err_cnt_cor
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic         rx_done_q;
    logic         armed;
    logic         new_frame;
    logic         cap_valid;
    logic         cap_par;
    logic [7:0]   cap_data;

    // armed holds off edge detection for one cycle after reset release so that
    // an rx_done level already high at release is not taken as a new frame.
    assign new_frame = armed & rx_done & ~rx_done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q <= 1'b0;
            armed     <= 1'b0;
            cap_valid <= 1'b0;
            cap_par   <= 1'b0;
            cap_data  <= 8'h00;
        end else begin
            rx_done_q <= rx_done;
            armed     <= 1'b1;
            cap_valid <= new_frame;
            if (new_frame) begin
                cap_data <= rx_data;
                cap_par  <= rx_parity_err;
            end
        end
    end

    logic [2:0]   syn;
    logic         par_all;
    logic [7:0]   flip_mask;
    logic [7:0]   fixed;
    logic [3:0]   dec_nibble;
    logic         dec_uncorr;
    logic         dec_corr;

    assign syn[0]  = cap_data[0] ^ cap_data[2] ^ cap_data[4] ^ cap_data[6];
    assign syn[1]  = cap_data[1] ^ cap_data[2] ^ cap_data[5] ^ cap_data[6];
    assign syn[2]  = cap_data[3] ^ cap_data[4] ^ cap_data[5] ^ cap_data[6];
    assign par_all = ^cap_data;

    always_comb begin
        flip_mask = 8'h00;
        if ((syn != 3'd0) && par_all) begin
            flip_mask[syn - 3'd1] = 1'b1;
        end
    end

    // Overall parity set means a single flip; with syndrome 0 that flip was p0 itself.
    assign fixed      = cap_data ^ flip_mask;
    assign dec_nibble = {fixed[6], fixed[5], fixed[4], fixed[2]};
    assign dec_uncorr = (syn != 3'd0) && !par_all;
    assign dec_corr   = par_all;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          frame_ok;
    logic          wr_en;
    logic          ovf;
    logic [4:0]    head;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = m_valid & m_ready;
    assign frame_ok = cap_valid & ~cap_par & ~dec_uncorr;
    assign wr_en    = frame_ok & (~full | pop);
    assign ovf      = frame_ok & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 5'd0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= {dec_corr, dec_nibble};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign m_valid     = ~empty;
    assign m_data      = m_valid ? head[3:0] : 4'h0;
    assign m_corrected = m_valid & head[4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_parity <= 1'b0;
            drop_ecc    <= 1'b0;
            drop_ovf    <= 1'b0;
        end else begin
            drop_parity <= cap_valid & cap_par;
            drop_ecc    <= cap_valid & ~cap_par & dec_uncorr;
            drop_ovf    <= ovf;
        end
    end

`ifdef RX_ERR_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_par <= '0;
            err_cnt_ecc <= '0;
            err_cnt_cor <= '0;
        end else begin
            if (cap_valid && cap_par && (err_cnt_par != CNT_MAX)) begin
                err_cnt_par <= err_cnt_par + 1'b1;
            end
            if (cap_valid && !cap_par && dec_uncorr && (err_cnt_ecc != CNT_MAX)) begin
                err_cnt_ecc <= err_cnt_ecc + 1'b1;
            end
            if (wr_en && dec_corr && (err_cnt_cor != CNT_MAX)) begin
                err_cnt_cor <= err_cnt_cor + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder; counter checks compile in with RX_ERR_CNT_EN.
module tb_rx_frame_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_err;
    logic [3:0] m_data;
    logic       m_corrected;
    logic       m_valid;
    logic       m_ready;
    logic       drop_parity;
    logic       drop_ecc;
    logic       drop_ovf;
`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt_par;
    logic [7:0] err_cnt_ecc;
    logic [7:0] err_cnt_cor;
`endif

    int checks   = 0;
    int failures = 0;
    int got_n;
    logic [3:0] got_d [16];
    logic       got_c [16];

    rx_frame_decoder #(.FIFO_DEPTH(4), .CNT_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .m_data        (m_data),
        .m_corrected   (m_corrected),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .drop_parity   (drop_parity),
        .drop_ecc      (drop_ecc),
        .drop_ovf      (drop_ovf)
`ifdef RX_ERR_CNT_EN
        ,
        .err_cnt_par   (err_cnt_par),
        .err_cnt_ecc   (err_cnt_ecc),
        .err_cnt_cor   (err_cnt_cor)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raises rx_done and returns at the falling edge after the decode edge.
    task automatic start_frame(input logic [7:0] d, input logic p);
        @(negedge clk);
        rx_data       = d;
        rx_parity_err = p;
        rx_done       = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        got_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!m_valid) break;
            got_d[got_n] = m_data;
            got_c[got_n] = m_corrected;
            got_n++;
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask

    initial begin
        reset         = 1'b0;
        rx_data       = 8'h00;
        rx_done       = 1'b0;
        rx_parity_err = 1'b0;
        m_ready       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_drops", 32'({drop_parity, drop_ecc, drop_ovf}), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // clean codeword, with the intermediate cycle showing no bypass
        @(negedge clk);
        rx_data = 8'hD2; rx_parity_err = 1'b0; rx_done = 1'b1;
        @(negedge clk);
        check("clean_latency", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("clean_valid", 32'(m_valid), 32'd1);
        check("clean_data", 32'(m_data), 32'hA);
        check("clean_corr", 32'(m_corrected), 32'd0);
        check("clean_drops", 32'({drop_parity, drop_ecc, drop_ovf}), 32'd0);
        end_frame();
        drain();
        check("clean_pop_n", 32'(got_n), 32'd1);
        check("clean_pop_empty", 32'(m_valid), 32'd0);

        start_frame(8'hC2, 1'b0);
        check("single_valid", 32'(m_valid), 32'd1);
        check("single_data", 32'(m_data), 32'hA);
        check("single_corr", 32'(m_corrected), 32'd1);
        end_frame();
        drain();

        start_frame(8'hC3, 1'b0);
        check("double_drop_ecc", 32'(drop_ecc), 32'd1);
        check("double_valid", 32'(m_valid), 32'd0);
        check("double_other", 32'({drop_parity, drop_ovf}), 32'd0);
        @(negedge clk);
        check("double_pulse_end", 32'(drop_ecc), 32'd0);
        end_frame();

        start_frame(8'hD2, 1'b1);
        check("par_drop", 32'(drop_parity), 32'd1);
        check("par_no_ecc", 32'(drop_ecc), 32'd0);
        check("par_valid", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("par_pulse_end", 32'(drop_parity), 32'd0);
        end_frame();

        // fill past capacity with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            start_frame(8'h00, 1'b0);
            check($sformatf("fill_ovf_%0d", i), 32'(drop_ovf), (i == 4) ? 32'd1 : 32'd0);
            end_frame();
        end
        check("full_valid", 32'(m_valid), 32'd1);
        check("full_head_stable", 32'(m_data), 32'd0);

        // frame decode coincides with a pop on a full FIFO
        @(negedge clk);
        rx_data = 8'hD2; rx_parity_err = 1'b0; rx_done = 1'b1;
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("popfull_no_ovf", 32'(drop_ovf), 32'd0);
        end_frame();
        drain();
        check("popfull_count", 32'(got_n), 32'd4);
        check("popfull_e0", 32'(got_d[0]), 32'h0);
        check("popfull_e2", 32'(got_d[2]), 32'h0);
        check("popfull_last", 32'(got_d[3]), 32'hA);

        // long rx_done level counts once
        @(negedge clk);
        rx_data = 8'hD2; rx_parity_err = 1'b0; rx_done = 1'b1;
        repeat (100) @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        drain();
        check("hold_count", 32'(got_n), 32'd1);
        check("hold_data", 32'(got_d[0]), 32'hA);

`ifdef RX_ERR_CNT_EN
        check("cnt_par", 32'(err_cnt_par), 32'd1);
        check("cnt_ecc", 32'(err_cnt_ecc), 32'd1);
        check("cnt_cor", 32'(err_cnt_cor), 32'd1);
`endif

        // reset while an entry is queued and a new frame is captured
        start_frame(8'hD2, 1'b0);
        end_frame();
        @(negedge clk);
        rx_data = 8'hC2; rx_done = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
`ifdef RX_ERR_CNT_EN
        check("midrst_cnt_cor", 32'(err_cnt_cor), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rel_high_valid", 32'(m_valid), 32'd0);
        check("rel_high_drops", 32'({drop_parity, drop_ecc, drop_ovf}), 32'd0);
        rx_done = 1'b0;
        @(negedge clk);
        start_frame(8'hD2, 1'b0);
        check("post_rst_valid", 32'(m_valid), 32'd1);
        check("post_rst_data", 32'(m_data), 32'hA);
        end_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
